// File: rtl/initialization_sequence_controller.sv
`default_nettype none
// ============================================================================
//  Module      : initialization_sequence_controller
//  Description : Host-write sequencer for the 8259A control logic. Detects
//                completed CPU writes, classifies each one as ICW1..ICW4 or
//                OCW1..OCW3, and walks the ICW1->ICW2->[ICW3]->[ICW4]
//                initialization sequence.
//  Ports       : clock, reset            - system clock, sync active-high reset
//                chip_select_n           - CS#, active low
//                write_enable_n          - WR#, active low
//                address                 - A0
//                data_bus_in[7:0]        - CPU data
//                internal_data_bus[7:0]  - byte of the last committed write
//                write_initial_command_word_1..4   - 1-cycle ICW strobes
//                write_operation_control_word_1..3 - 1-cycle OCW strobes
//                in_initialization       - high from reset/ICW1 until READY
//                initialization_complete - high in READY only
//  Revision    : 1.0 - initial release
// ============================================================================
module initialization_sequence_controller (
    input  logic       clock,
    input  logic       reset,
    input  logic       chip_select_n,
    input  logic       write_enable_n,
    input  logic       address,
    input  logic [7:0] data_bus_in,
    output logic [7:0] internal_data_bus,
    output logic       write_initial_command_word_1,
    output logic       write_initial_command_word_2,
    output logic       write_initial_command_word_3,
    output logic       write_initial_command_word_4,
    output logic       write_operation_control_word_1,
    output logic       write_operation_control_word_2,
    output logic       write_operation_control_word_3,
    output logic       in_initialization,
    output logic       initialization_complete
);

    typedef enum logic [2:0] {
        ST_UNINIT = 3'd0,
        ST_ICW2   = 3'd1,
        ST_ICW3   = 3'd2,
        ST_ICW4   = 3'd3,
        ST_READY  = 3'd4
    } state_t;

    state_t     r_state;
    logic       r_req;
    logic       r_cap_a0;
    logic [7:0] r_cap_data;
    logic       r_sngl;
    logic       r_ic4;

    logic       w_req;
    logic       w_commit;
    logic       w_is_icw1;

    assign w_req     = ~chip_select_n & ~write_enable_n;
    // A write takes effect only when it ends, so data may settle while held.
    assign w_commit  = r_req & ~w_req;
    assign w_is_icw1 = ~r_cap_a0 & r_cap_data[4];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state                        <= ST_UNINIT;
            r_req                          <= 1'b0;
            r_cap_a0                       <= 1'b0;
            r_cap_data                     <= 8'h00;
            r_sngl                         <= 1'b0;
            r_ic4                          <= 1'b0;
            internal_data_bus              <= 8'h00;
            write_initial_command_word_1   <= 1'b0;
            write_initial_command_word_2   <= 1'b0;
            write_initial_command_word_3   <= 1'b0;
            write_initial_command_word_4   <= 1'b0;
            write_operation_control_word_1 <= 1'b0;
            write_operation_control_word_2 <= 1'b0;
            write_operation_control_word_3 <= 1'b0;
            in_initialization              <= 1'b1;
            initialization_complete        <= 1'b0;
        end else begin
            r_req <= w_req;
            if (w_req) begin
                r_cap_a0   <= address;
                r_cap_data <= data_bus_in;
            end

            // Strobes are single-cycle by default.
            write_initial_command_word_1   <= 1'b0;
            write_initial_command_word_2   <= 1'b0;
            write_initial_command_word_3   <= 1'b0;
            write_initial_command_word_4   <= 1'b0;
            write_operation_control_word_1 <= 1'b0;
            write_operation_control_word_2 <= 1'b0;
            write_operation_control_word_3 <= 1'b0;

            if (w_commit) begin
                internal_data_bus <= r_cap_data;
                if (w_is_icw1) begin
                    // ICW1 restarts the sequence from any state.
                    write_initial_command_word_1 <= 1'b1;
                    r_sngl                       <= r_cap_data[1];
                    r_ic4                        <= r_cap_data[0];
                    r_state                      <= ST_ICW2;
                    in_initialization            <= 1'b1;
                    initialization_complete      <= 1'b0;
                end else begin
                    case (r_state)
                        ST_UNINIT: begin
                            r_state <= ST_UNINIT;
                        end
                        ST_ICW2: begin
                            if (r_cap_a0) begin
                                write_initial_command_word_2 <= 1'b1;
                                if (!r_sngl) begin
                                    r_state <= ST_ICW3;
                                end else if (r_ic4) begin
                                    r_state <= ST_ICW4;
                                end else begin
                                    r_state                 <= ST_READY;
                                    in_initialization       <= 1'b0;
                                    initialization_complete <= 1'b1;
                                end
                            end
                        end
                        ST_ICW3: begin
                            if (r_cap_a0) begin
                                write_initial_command_word_3 <= 1'b1;
                                if (r_ic4) begin
                                    r_state <= ST_ICW4;
                                end else begin
                                    r_state                 <= ST_READY;
                                    in_initialization       <= 1'b0;
                                    initialization_complete <= 1'b1;
                                end
                            end
                        end
                        ST_ICW4: begin
                            if (r_cap_a0) begin
                                write_initial_command_word_4 <= 1'b1;
                                r_state                      <= ST_READY;
                                in_initialization            <= 1'b0;
                                initialization_complete      <= 1'b1;
                            end
                        end
                        ST_READY: begin
                            if (r_cap_a0) begin
                                write_operation_control_word_1 <= 1'b1;
                            end else if (r_cap_data[3]) begin
                                write_operation_control_word_3 <= 1'b1;
                            end else begin
                                write_operation_control_word_2 <= 1'b1;
                            end
                        end
                        default: begin
                            r_state <= ST_UNINIT;
                        end
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_initialization_sequence_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_initialization_sequence_controller
//  Description : Self-checking bench for initialization_sequence_controller.
//                Table of single writes with hand-computed strobe/status
//                results, plus hand-written multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_initialization_sequence_controller;

    // Strobe vector bit order: {ocw3, ocw2, ocw1, icw4, icw3, icw2, icw1}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_ICW1 = 7'b0000001;
    localparam logic [6:0] C_ICW2 = 7'b0000010;
    localparam logic [6:0] C_ICW3 = 7'b0000100;
    localparam logic [6:0] C_ICW4 = 7'b0001000;
    localparam logic [6:0] C_OCW1 = 7'b0010000;
    localparam logic [6:0] C_OCW2 = 7'b0100000;
    localparam logic [6:0] C_OCW3 = 7'b1000000;

    logic       clk;
    logic       rst;
    logic       cs_n;
    logic       wr_n;
    logic       a0;
    logic [7:0] din;
    logic [7:0] dbus;
    logic       icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3;
    logic       in_init;
    logic       complete;
    logic [6:0] w_strb;

    assign w_strb = {ocw3, ocw2, ocw1, icw4, icw3, icw2, icw1};

    initialization_sequence_controller dut (
        .clock                          (clk),
        .reset                          (rst),
        .chip_select_n                  (cs_n),
        .write_enable_n                 (wr_n),
        .address                        (a0),
        .data_bus_in                    (din),
        .internal_data_bus              (dbus),
        .write_initial_command_word_1   (icw1),
        .write_initial_command_word_2   (icw2),
        .write_initial_command_word_3   (icw3),
        .write_initial_command_word_4   (icw4),
        .write_operation_control_word_1 (ocw1),
        .write_operation_control_word_2 (ocw2),
        .write_operation_control_word_3 (ocw3),
        .in_initialization              (in_init),
        .initialization_complete        (complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input logic [6:0] strb, input logic ini,
                           input logic cmp);
        chk({name, ".strobe"}, {1'b0, w_strb}, {1'b0, strb});
        chk({name, ".in_init"}, {7'd0, in_init}, {7'd0, ini});
        chk({name, ".complete"}, {7'd0, complete}, {7'd0, cmp});
    endtask

    typedef struct {
        logic       a0;
        logic [7:0] d;
        logic [6:0] strb;
        logic       ini;
        logic       cmp;
    } vec_t;

    vec_t vecs[18];

    // One write of one cycle; checks strobe in the cycle after WR# rises and
    // that the strobe is gone one cycle later.
    task automatic do_write(input string name, input logic wa0, input logic [7:0] wd,
                            input logic [6:0] strb, input logic ini, input logic cmp);
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; a0 = wa0; din = wd;
        @(negedge clk);
        chk({name, ".held"}, {1'b0, w_strb}, 8'h00);
        cs_n = 1'b1; wr_n = 1'b1; din = 8'hxx;
        @(negedge clk);
        chk_out(name, strb, ini, cmp);
        if (strb != C_NONE) chk({name, ".data"}, dbus, wd);
        @(negedge clk);
        chk({name, ".after"}, {1'b0, w_strb}, 8'h00);
    endtask

    initial begin
        logic [7:0] held_vals [5];
        n_cmp = 0;
        n_bad = 0;

        vecs[0]  = '{1'b1, 8'hFF, C_NONE, 1'b1, 1'b0};  // UNINIT ignores A0=1
        vecs[1]  = '{1'b0, 8'h13, C_ICW1, 1'b1, 1'b0};  // SNGL=1 IC4=1
        vecs[2]  = '{1'b1, 8'h20, C_ICW2, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 8'h01, C_ICW4, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 8'hFB, C_OCW1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 8'h20, C_OCW2, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 8'h0B, C_OCW3, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 8'h11, C_ICW1, 1'b1, 1'b0};  // SNGL=0 IC4=1
        vecs[8]  = '{1'b1, 8'h08, C_ICW2, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 8'h04, C_ICW3, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 8'h01, C_ICW4, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 8'h12, C_ICW1, 1'b1, 1'b0};  // SNGL=1 IC4=0
        vecs[12] = '{1'b1, 8'h40, C_ICW2, 1'b0, 1'b1};  // straight to READY
        vecs[13] = '{1'b0, 8'h13, C_ICW1, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 8'h55, C_ICW2, 1'b1, 1'b0};  // now awaiting ICW4
        vecs[15] = '{1'b0, 8'h11, C_ICW1, 1'b1, 1'b0};  // restart mid-sequence
        vecs[16] = '{1'b1, 8'h08, C_ICW2, 1'b1, 1'b0};  // now awaiting ICW3
        vecs[17] = '{1'b0, 8'h08, C_NONE, 1'b1, 1'b0};  // A0=0 D4=0 ignored

        cs_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; din = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_out("reset", C_NONE, 1'b1, 1'b0);
        chk("reset.data", dbus, 8'h00);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            do_write($sformatf("vec%0d", i), vecs[i].a0, vecs[i].d,
                     vecs[i].strb, vecs[i].ini, vecs[i].cmp);
        end

        // Reset while awaiting ICW3: everything returns to reset values.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_out("rst_icw3", C_NONE, 1'b1, 1'b0);
        chk("rst_icw3.data", dbus, 8'h00);
        rst = 1'b0;
        // Back in UNINIT, so an A0=1 write must not strobe ICW3.
        do_write("post_rst", 1'b1, 8'h01, C_NONE, 1'b1, 1'b0);

        // Long write with changing data: one strobe carrying the last byte.
        do_write("held_icw1", 1'b0, 8'h13, C_ICW1, 1'b1, 1'b0);
        held_vals[0] = 8'h10; held_vals[1] = 8'h20; held_vals[2] = 8'h30;
        held_vals[3] = 8'h40; held_vals[4] = 8'h50;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; din = held_vals[i];
        end
        @(negedge clk);
        chk("held.nostrobe", {1'b0, w_strb}, 8'h00);
        cs_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
        chk_out("held", C_ICW2, 1'b1, 1'b0);
        chk("held.data", dbus, 8'h50);
        @(negedge clk);
        chk("held.after", {1'b0, w_strb}, 8'h00);

        // CS# rising before WR# still ends the write (awaiting ICW4 now).
        cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; din = 8'h03;
        @(negedge clk);
        cs_n = 1'b1;
        @(negedge clk);
        chk_out("cs_first", C_ICW4, 1'b0, 1'b1);
        chk("cs_first.data", dbus, 8'h03);
        wr_n = 1'b1;
        @(negedge clk);
        chk("cs_first.after", {1'b0, w_strb}, 8'h00);
        chk("cs_first.hold", dbus, 8'h03);

        // Back-to-back writes with one idle cycle in READY.
        cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; din = 8'hA5;
        @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
        chk_out("b2b_0", C_OCW1, 1'b0, 1'b1);
        cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b0; din = 8'h08;
        @(negedge clk);
        chk("b2b_gap", {1'b0, w_strb}, 8'h00);
        cs_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
        chk_out("b2b_1", C_OCW3, 1'b0, 1'b1);
        chk("b2b_1.data", dbus, 8'h08);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
